ram_dp: RTL and testbench
=========================

RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 Parameter DataWidth, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NPos, default 1024: number of words; any value >= 2, not required to be a power of two.
REQ-003 Parameter NPosWidth, default $clog2(NPos): address width.
REQ-004 Port clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_i  input  1: reset, asynchronous and active-high.
REQ-006 Port clr_i  input  1: request a full memory clear.
REQ-007 Port busy_o  output  1: clear in progress.
REQ-008 Port we_i  input  1: write enable.
REQ-009 Port wa_i  input  NPosWidth: write address.
REQ-010 Port wd_i  input  DataWidth: write data.
REQ-011 Port wbe_i  input  DataWidth/8: byte enables; bit k covers wd_i[8k+7:8k].
REQ-012 Port re_i  input  1: read enable.
REQ-013 Port ra_i  input  NPosWidth: read address.
REQ-014 Port rd_o  output  DataWidth: registered read data.
REQ-015 Port rvalid_o  output  1: rd_o holds data for a read accepted the previous cycle.

Function
REQ-016 Independent write and read ports SHALL both be usable in the same cycle.
REQ-017 Write: when we_i=1 and busy_o=0, each byte k with wbe_i[k]=1 SHALL be updated at mem[wa_i]; bytes with wbe_i[k]=0 SHALL be unchanged; wbe_i=0 SHALL write nothing.
REQ-018 Read latency SHALL be 1: re_i=1 with busy_o=0 at edge N gives rd_o=mem[ra_i] and rvalid_o=1 after edge N+1.
REQ-019 Without an accepted read, rvalid_o SHALL be 0 and rd_o SHALL hold its last value.
REQ-020 Out-of-range address (>= NPos): the write SHALL be dropped; the read SHALL return all zeros with rvalid_o=1.
REQ-021 Clear FSM SHALL have states IDLE and CLEAR plus a NPosWidth-bit clear counter.
REQ-022 IDLE->CLEAR SHALL occur when clr_i=1; the counter SHALL load 0.
REQ-023 In CLEAR, mem[counter] SHALL be written with zero each cycle and the counter SHALL increment; after writing NPos-1, the FSM SHALL return to IDLE.
REQ-024 A clear SHALL last exactly NPos cycles; busy_o SHALL be 1 exactly while in CLEAR.
REQ-025 While busy_o=1, we_i and re_i SHALL be ignored, rvalid_o SHALL be 0, and clr_i SHALL be ignored (no restart).
REQ-026 A read accepted in the last IDLE cycle before CLEAR SHALL still complete normally.

Reset
REQ-027 Asserting rst_i SHALL immediately force state CLEAR, counter 0, busy_o=1, rvalid_o=0 and rd_o=0.
REQ-028 After rst_i deasserts, the block SHALL clear all NPos words and then enter IDLE. Memory contents SHALL never be reset directly; only the clear FSM zeroes them.
REQ-029 Reset asserted mid-clear SHALL restart the clear from address 0.

Configuration
REQ-030 Macro RAM_DP_FWD_EN selects the same-cycle same-address read/write behaviour (accepted read and write with ra_i==wa_i).
REQ-031 With RAM_DP_FWD_EN defined, rd_o SHALL return the new data: enabled bytes from wd_i, other bytes from the old word.
REQ-032 Without RAM_DP_FWD_EN, rd_o SHALL return the old word (read-before-write).
REQ-033 In both builds, the write itself SHALL be identical.

Verification
REQ-034 Release rst_i -> busy_o=1 for exactly 1024 cycles, then 0; a subsequent read of address 1023 returns 0x00000000.
REQ-035 Write addr 5 = 0xAABBCCDD with wbe_i=4'b1111, then addr 5 = 0x11223344 with wbe_i=4'b0101; read 5 -> rd_o=0xAA22CC44 one cycle after re_i, rvalid_o pulses once.
REQ-036 Same cycle: write addr 7 = 0xDEADBEEF with wbe_i=4'b1111 and read addr 7, where addr 7 previously held 0x0 -> rd_o=0xDEADBEEF with RAM_DP_FWD_EN; 0x00000000 without it.
REQ-037 Pulse clr_i, then assert we_i and re_i during busy_o -> no memory change, rvalid_o stays 0; a second clr_i pulse mid-clear does not extend busy_o beyond NPos cycles.
REQ-038 Assert rst_i at clear count 300 -> busy_o stays 1 and, after release, lasts a full 1024 cycles; rd_o=0 during reset.
REQ-039 With NPos=100, write addr 120 = 0x5, then read addr 120 -> rd_o=0, rvalid_o=1; addr 0..99 unaffected.

Source files
------------

// File: rtl/ram_dp.sv
// Dual-port RAM with byte-enabled writes, 1-cycle registered reads and a sequential clear FSM.
// Define RAM_DP_FWD_EN to forward same-cycle same-address write data to the read port.
module ram_dp #(
    parameter int DataWidth = 32,
    parameter int NPos      = 1024,
    parameter int NPosWidth = $clog2(NPos)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    output logic                   busy_o,
    input  logic                   we_i,
    input  logic [NPosWidth-1:0]   wa_i,
    input  logic [DataWidth-1:0]   wd_i,
    input  logic [DataWidth/8-1:0] wbe_i,
    input  logic                   re_i,
    input  logic [NPosWidth-1:0]   ra_i,
    output logic [DataWidth-1:0]   rd_o,
    output logic                   rvalid_o
);

    // state | meaning
    // IDLE  | normal read/write operation
    // CLEAR | zeroing mem[cnt_q] each cycle, user ports ignored
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int                 NBytes  = DataWidth / 8;
    localparam logic [NPosWidth:0] NPosExt = (NPosWidth + 1)'(NPos);
    localparam logic [NPosWidth-1:0] LastAddr = NPosWidth'(NPos - 1);

    state_e               state_q, state_d;
    logic [NPosWidth-1:0] cnt_q, cnt_d;
    logic [DataWidth-1:0] rd_q, rd_d;
    logic                 rvalid_q, rvalid_d;
    logic [DataWidth-1:0] mem [NPos];

    logic                 busy;
    logic                 wa_in_range, ra_in_range;
    logic                 we_ok, re_ok;
    logic [DataWidth-1:0] old_word;

    assign busy        = (state_q == CLEAR);
    assign wa_in_range = ({1'b0, wa_i} < NPosExt);
    assign ra_in_range = ({1'b0, ra_i} < NPosExt);
    assign we_ok       = we_i && !busy && wa_in_range;
    assign re_ok       = re_i && !busy;
    assign old_word    = ra_in_range ? mem[ra_i] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            rd_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + NPosWidth'(1);
                if (cnt_q == LastAddr) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef RAM_DP_FWD_EN
    logic [DataWidth-1:0] fwd_word;

    always_comb begin
        fwd_word = old_word;
        for (int k = 0; k < NBytes; k++) begin
            if (wbe_i[k]) fwd_word[8*k +: 8] = wd_i[8*k +: 8];
        end
    end
`endif

    always_comb begin
        rd_d     = rd_q;
        rvalid_d = 1'b0;
        if (re_ok) begin
            rvalid_d = 1'b1;
            rd_d     = old_word;
`ifdef RAM_DP_FWD_EN
            if (we_ok && (wa_i == ra_i)) rd_d = fwd_word;
`endif
        end
    end

    // Storage has no reset; only the clear sequence zeroes it.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (we_ok) begin
            for (int k = 0; k < NBytes; k++) begin
                if (wbe_i[k]) mem[wa_i][8*k +: 8] <= wd_i[8*k +: 8];
            end
        end
    end

    assign busy_o   = busy;
    assign rd_o     = rd_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_ram_dp.sv
// Directed self-checking bench for ram_dp: a 1024-word instance plus a 100-word instance
// for out-of-range addressing. Expectations follow RAM_DP_FWD_EN when it is defined.
module tb_ram_dp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        clr, busy, we, re, rvalid;
    logic [9:0]  wa, ra;
    logic [31:0] wd, rd;
    logic [3:0]  wbe;

    logic        s_clr, s_busy, s_we, s_re, s_rvalid;
    logic [6:0]  s_wa, s_ra;
    logic [31:0] s_wd, s_rd;
    logic [3:0]  s_wbe;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_dp #(.DataWidth(32), .NPos(1024)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .busy_o(busy),
        .we_i(we), .wa_i(wa), .wd_i(wd), .wbe_i(wbe),
        .re_i(re), .ra_i(ra), .rd_o(rd), .rvalid_o(rvalid)
    );

    ram_dp #(.DataWidth(32), .NPos(100)) dut_s (
        .clk_i(clk), .rst_i(rst), .clr_i(s_clr), .busy_o(s_busy),
        .we_i(s_we), .wa_i(s_wa), .wd_i(s_wd), .wbe_i(s_wbe),
        .re_i(s_re), .ra_i(s_ra), .rd_o(s_rd), .rvalid_o(s_rvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; we = 0; re = 0; wa = '0; ra = '0; wd = '0; wbe = '0;
        s_clr = 0; s_we = 0; s_re = 0; s_wa = '0; s_ra = '0; s_wd = '0; s_wbe = '0;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        #2 rst = 1'b1;
        #3;
        n_tests++;
        if (busy !== 1'b1 || rvalid !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state busy=%b rvalid=%b rd=%h required 1 0 00000000", busy, rvalid, rd);
        end
        tick(); tick();
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy === 1'b1 && n < 3000);
        n_tests++;
        if (n != 1024) begin
            n_fail++;
            $display("FAIL reset_clear_len cycles=%0d required 1024", n);
        end
        re = 1; ra = 10'd1023;
        tick();
        re = 0;
        n_tests++;
        if (rd !== 32'h0 || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_1023 rd=%h rvalid=%b required 00000000 1", rd, rvalid);
        end
        n_tests++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL small_clear_done busy=%b required 0", s_busy);
        end
    endtask

    task automatic test_byte_enable();
        we = 1; wa = 10'd5; wd = 32'hAABBCCDD; wbe = 4'b1111;
        tick();
        wd = 32'h11223344; wbe = 4'b0101;
        tick();
        wd = 32'hFFFFFFFF; wbe = 4'b0000;
        tick();
        we = 0; re = 1; ra = 10'd5;
        tick();
        re = 0;
        n_tests++;
        if (rd !== 32'hAA22CC44 || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_enable rd=%h rvalid=%b required aa22cc44 1", rd, rvalid);
        end
        tick();
        n_tests++;
        if (rvalid !== 1'b0 || rd !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL rvalid_pulse rvalid=%b rd=%h required 0 aa22cc44", rvalid, rd);
        end
        we = 1; wa = 10'd6; wd = 32'h0BADF00D; wbe = 4'b1010;
        re = 1; ra = 10'd5;
        tick();
        we = 0;
        ra = 10'd6;
        tick();
        re = 0;
        n_tests++;
        if (rd !== 32'h0B00F000) begin
            n_fail++;
            $display("FAIL partial_write rd=%h required 0b00f000", rd);
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] exp;
`ifdef RAM_DP_FWD_EN
        exp = 32'hDEADBEEF;
`else
        exp = 32'h00000000;
`endif
        we = 1; wa = 10'd7; wd = 32'hDEADBEEF; wbe = 4'b1111;
        re = 1; ra = 10'd7;
        tick();
        we = 0; wbe = 4'b0000;
        n_tests++;
        if (rd !== exp || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL same_addr rd=%h rvalid=%b required %h 1", rd, rvalid, exp);
        end
        tick();
        re = 0;
        n_tests++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL same_addr_stored rd=%h required deadbeef", rd);
        end
    endtask

    task automatic test_clear_ignore();
        int n;
        int rv_seen;
        we = 1; wa = 10'd10; wd = 32'h12345678; wbe = 4'b1111;
        tick();
        we = 0;
        clr = 1; re = 1; ra = 10'd10;
        tick();
        clr = 0;
        n_tests++;
        if (busy !== 1'b1 || rvalid !== 1'b1 || rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL read_before_clear busy=%b rvalid=%b rd=%h required 1 1 12345678", busy, rvalid, rd);
        end
        we = 1; wa = 10'd3; wd = 32'hCAFEF00D; wbe = 4'b1111;
        re = 1; ra = 10'd3;
        n = 1;
        rv_seen = 0;
        do begin
            clr = (n == 500);
            tick();
            if (rvalid !== 1'b0) rv_seen++;
            if (busy === 1'b1) n++;
        end while (busy === 1'b1 && n < 3000);
        we = 0; re = 0; clr = 0;
        n_tests++;
        if (n != 1024) begin
            n_fail++;
            $display("FAIL clr_len cycles=%0d required 1024", n);
        end
        n_tests++;
        if (rv_seen != 0) begin
            n_fail++;
            $display("FAIL rvalid_in_clear count=%0d required 0", rv_seen);
        end
        re = 1; ra = 10'd3;
        tick();
        ra = 10'd10;
        n_tests++;
        if (rd !== 32'h0 || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ignored rd=%h rvalid=%b required 00000000 1", rd, rvalid);
        end
        tick();
        re = 0;
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL cleared_word rd=%h required 00000000", rd);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int ok;
        we = 1; wa = 10'd20; wd = 32'h5A5A5A5A; wbe = 4'b1111;
        tick();
        we = 0; re = 1; ra = 10'd20;
        tick();
        re = 0;
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 299; i++) tick();
        n_tests++;
        if (rd !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("FAIL pre_reset_rd rd=%h required 5a5a5a5a", rd);
        end
        rst = 1;
        #1;
        n_tests++;
        if (busy !== 1'b1 || rd !== 32'h0 || rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset busy=%b rd=%h rvalid=%b required 1 00000000 0", busy, rd, rvalid);
        end
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy !== 1'b1 || rd !== 32'h0) ok = 0;
        end
        rst = 0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy === 1'b1 && n < 3000);
        n_tests++;
        if (ok != 1 || n != 1024) begin
            n_fail++;
            $display("FAIL reset_restart held=%0d cycles=%0d required 1 1024", ok, n);
        end
    endtask

    task automatic test_out_of_range();
        int bad;
        s_we = 1; s_wa = 7'd50; s_wd = 32'hA5A5A5A5; s_wbe = 4'b1111;
        tick();
        s_wa = 7'd120; s_wd = 32'h00000005;
        tick();
        s_we = 0; s_re = 1; s_ra = 7'd50;
        tick();
        s_ra = 7'd120;
        n_tests++;
        if (s_rd !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL small_inrange rd=%h required a5a5a5a5", s_rd);
        end
        tick();
        n_tests++;
        if (s_rd !== 32'h0 || s_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL out_of_range rd=%h rvalid=%b required 00000000 1", s_rd, s_rvalid);
        end
        bad = 0;
        for (int a = 0; a < 100; a++) begin
            s_ra = 7'(a);
            tick();
            if (s_rd !== ((a == 50) ? 32'hA5A5A5A5 : 32'h0) || s_rvalid !== 1'b1) bad++;
        end
        s_re = 0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL small_sweep bad_words=%0d required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_same_addr();
        test_clear_ignore();
        test_reset_mid();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
